// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryption core, one round step per clock
//
// Purpose:
//   Takes a plaintext block and the initial cipher key. The round-key bundle comes
//   from the key-expansion stage. The block is encrypted one step per clock:
//   SubBytes, ShiftRows, MixColumns, AddRoundKey. The ciphertext is held until the
//   output buffer accepts it. Only one block is in flight at a time.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   in_valid    plaintext/key0 valid
//   in_ready    core can accept a block (idle, keys valid, not in reset)
//   plaintext   128-bit block, byte 0 in [127:120], column-major state
//   key0        cipher key for the initial AddRoundKey, same byte order
//   round_keys  NROUNDS round keys, round 1 in the most significant 128 bits
//   keys_valid  round_keys bundle valid; gates acceptance only
//   sbox        256-entry S-box table, entry 0 in [2047:2040]
//   out_valid   ciphertext valid
//   out_ready   downstream accepts ciphertext
//   ciphertext  result, same byte order as plaintext
//   busy        high from accept until the output handshake
//   round       current round number (debug), 0 when idle

module aes_encrypt_iter #(
  parameter int NROUNDS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           plaintext,
  input  logic [127:0]           key0,
  input  logic [128*NROUNDS-1:0] round_keys,
  input  logic                   keys_valid,
  input  logic [2047:0]          sbox,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           ciphertext,
  output logic                   busy,
  output logic [3:0]             round
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SUB   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_MIX   = 3'd3;
  localparam logic [2:0] S_ARK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  logic [2:0]   fsm;
  logic [127:0] st;
  logic [3:0]   rnd;

  logic [127:0] sub_st;
  logic [127:0] shift_st;
  logic [127:0] mix_st;
  logic [127:0] rk;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // S(x) sits at bits (255-x)*8+7 down to (255-x)*8.
  // That top index is simply {~x, 3'b111}.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return sbox[{~x, 3'b111} -: 8];
  endfunction

  // SubBytes on every byte of the state.
  always_comb begin
    sub_st = '0;
    for (int i = 0; i < 16; i++) begin
      sub_st[127-8*i -: 8] = sbox_lookup(st[127-8*i -: 8]);
    end
  end

  // ShiftRows. Byte index is 4*column + row.
  // Row r of column c takes the byte from column (c+r) mod 4.
  always_comb begin
    shift_st = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_st[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  // MixColumns, using the xtime form of the matrix multiply:
  //   b'_i = b_i ^ xtime(b_i ^ b_{i+1}) ^ (b0^b1^b2^b3)
  always_comb begin
    logic [7:0] b0, b1, b2, b3, t;
    mix_st = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = st[127-8*(4*c+0) -: 8];
      b1 = st[127-8*(4*c+1) -: 8];
      b2 = st[127-8*(4*c+2) -: 8];
      b3 = st[127-8*(4*c+3) -: 8];
      t  = b0 ^ b1 ^ b2 ^ b3;
      mix_st[127-8*(4*c+0) -: 8] = b0 ^ xtime(b0 ^ b1) ^ t;
      mix_st[127-8*(4*c+1) -: 8] = b1 ^ xtime(b1 ^ b2) ^ t;
      mix_st[127-8*(4*c+2) -: 8] = b2 ^ xtime(b2 ^ b3) ^ t;
      mix_st[127-8*(4*c+3) -: 8] = b3 ^ xtime(b3 ^ b0) ^ t;
    end
  end

  // Round-key select. A compare-per-round mux keeps the index in range
  // even when rnd is 0 or above NROUNDS.
  always_comb begin
    rk = '0;
    for (int r = 1; r <= NROUNDS; r++) begin
      if (rnd == 4'(r)) begin
        rk = round_keys[128*(NROUNDS-r) +: 128];
      end
    end
  end

  // rst_n is folded in so in_ready stays low while reset is asserted.
  // Without it, the IDLE state alone would raise in_ready during reset.
  assign in_ready   = rst_n & keys_valid & (fsm == S_IDLE);
  assign out_valid  = (fsm == S_DONE);
  assign busy       = (fsm != S_IDLE);
  assign round      = rnd;
  assign ciphertext = (fsm == S_DONE) ? st : 128'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      st  <= '0;
      rnd <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            st  <= plaintext ^ key0;
            rnd <= 4'd1;
            fsm <= S_SUB;
          end
        end
        S_SUB: begin
          st  <= sub_st;
          fsm <= S_SHIFT;
        end
        S_SHIFT: begin
          st <= shift_st;
          // The final round has no MixColumns.
          fsm <= (rnd < LAST_ROUND) ? S_MIX : S_ARK;
        end
        S_MIX: begin
          st  <= mix_st;
          fsm <= S_ARK;
        end
        S_ARK: begin
          st <= st ^ rk;
          if (rnd == LAST_ROUND) begin
            fsm <= S_DONE;
          end else begin
            rnd <= rnd + 4'd1;
            fsm <= S_SUB;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm <= S_IDLE;
            rnd <= '0;
          end
        end
        default: begin
          fsm <= S_IDLE;
          rnd <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - directed vector bench for aes_encrypt_iter
module tb_aes_encrypt_iter;

  localparam int NR = 10;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      plaintext;
  logic [127:0]      key0;
  logic [128*NR-1:0] round_keys;
  logic              keys_valid;
  logic [2047:0]     sbox;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      ciphertext;
  logic              busy;
  logic [3:0]        round;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.NROUNDS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key0       (key0),
    .round_keys (round_keys),
    .keys_valid (keys_valid),
    .sbox       (sbox),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round)
  );

  // Upstream must keep the key bundle and the S-box stable while a block is in flight.
  logic [128*NR-1:0] rk_q;
  logic [2047:0]     sbox_q;
  logic              busy_q = 1'b0;
  always @(posedge clk) begin
    assert (!(busy && busy_q) || (round_keys === rk_q && sbox === sbox_q))
      else $error("FAIL key_bundle_stability");
    busy_q <= busy;
    rk_q   <= round_keys;
    sbox_q <= sbox;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX;
    return t[2047-8*int'(x) -: 8];
  endfunction

  // Independent AES-128 key expansion, producing the round-key bundle.
  function automatic logic [128*NR-1:0] expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [128*NR-1:0] o;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int r = 1; r <= NR; r++) o[128*(NR-r) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  typedef struct {
    string        name;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  task automatic load(input vec_t v);
    plaintext  = v.pt;
    key0       = v.key;
    round_keys = expand(v.key);
  endtask

  // Present v, wait for accept, return edges from accept to out_valid.
  task automatic start_and_wait(input vec_t v, output int lat);
    int n;
    load(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({v.name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({v.name, "_round1"}, round, 4'd1);
    lat = 0;
    while (!out_valid && lat < 80) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    out_ready = 1'b0;
    start_and_wait(v, lat);
    check({v.name, "_latency"}, lat, 39);
    check({v.name, "_ct"}, ciphertext, v.ct);
    check({v.name, "_busy_done"}, busy, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, "_idle_after"}, {out_valid, busy, in_ready, round}, {3'b001, 4'd0});
  endtask

  initial begin
    int lat, n, bad;

    vecs[0] = '{"fips_b",   128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{"fips_c1",  128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"zero_key", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n      = 1'b0;
    sbox       = SBOX;
    keys_valid = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    load(vecs[0]);

    // Reset state: even with in_valid and keys_valid high, nothing is ready or accepted.
    #7;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_outputs", {out_valid, busy, round, ciphertext}, '0);
    in_valid = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Backpressure: the result must hold for 20 cycles, then see exactly one handshake.
    start_and_wait(vecs[0], lat);
    check("bp_latency", lat, 39);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || ciphertext !== vecs[0].ct || in_ready !== 1'b0) bad++;
    end
    check("bp_hold_errors", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {out_valid, busy, in_ready}, 3'b001);

    // keys_valid low blocks acceptance.
    keys_valid = 1'b0;
    in_valid   = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("nokeys_errors", bad, 0);
    in_valid   = 1'b0;
    keys_valid = 1'b1;
    #1 check("nokeys_ready_back", in_ready, 1'b1);

    // Reset at round 5 aborts the block.
    load(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (round != 4'd5 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("mid_reset_reached_r5", round, 4'd5);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {in_ready, out_valid, busy, round, ciphertext}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // Back-to-back blocks with out_ready tied high.
    out_ready = 1'b1;
    load(vecs[0]);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 80) begin
      @(posedge clk); #1; lat++;
    end
    check("b2b_a_latency", lat, 39);
    check("b2b_a_ct", ciphertext, vecs[0].ct);
    @(posedge clk); #1;
    check("b2b_a_handshake", {out_valid, in_ready}, 2'b01);
    load(vecs[1]);
    lat = 0;
    while (!out_valid && lat < 80) begin
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check("b2b_b_gap", lat, 40);
    check("b2b_b_ct", ciphertext, vecs[1].ct);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_b_idle", {out_valid, busy}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
